key_bounce_gen: RTL

Synthesizable push-button emulator: on request it drives an active-low key line through press bounce, stable hold, release bounce and a quiet gap. Bounce is generated from an LFSR. Output is registered and feeds key_filter directly, for on-board self-test and closed-loop simulation of the debounce path. One emulated keypress per start request.

---
 rtl/key_bounce_gen.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/key_bounce_gen.sv
`default_nettype none
// ============================================================================
// Module   : key_bounce_gen
// Brief    : Push-button emulator. Each accepted start request drives the
//            active-low key line through press bounce, a stable hold, release
//            bounce and a quiet gap, then returns to idle with a done pulse.
// Options  : KEY_BOUNCE_GEN_BOUNCE_EN - when defined, bounce phases follow
//            bit 0 of a 16-bit LFSR; when undefined, the LFSR is removed and
//            each press produces exactly one falling and one rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module key_bounce_gen #(
    parameter logic [15:0] CNT_BOUNCE = 16'd10,
    parameter logic [15:0] CNT_HOLD   = 16'd30,
    parameter logic [15:0] CNT_GAP    = 16'd10,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    output logic       key_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] press_cnt
);

    // A zero seed would lock the LFSR, so it is replaced by a known-good value
    localparam logic [15:0] c_SEED = (LFSR_SEED == 16'd0) ? 16'hACE1 : LFSR_SEED;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRESS_B = 3'd1,
        S_HOLD    = 3'd2,
        S_REL_B   = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        key_q, key_d;
    logic        done_q, done_d;
    logic [7:0]  press_cnt_q, press_cnt_d;

    logic [15:0] w_phase_len;
    logic        w_phase_last;
    logic        w_bounce_press;
    logic        w_bounce_rel;

    // Length of the phase the FSM is currently in
    always_comb begin
        w_phase_len = 16'd1;
        case (state_q)
            S_PRESS_B, S_REL_B: w_phase_len = CNT_BOUNCE;
            S_HOLD:             w_phase_len = CNT_HOLD;
            S_GAP:              w_phase_len = CNT_GAP;
            default:            w_phase_len = 16'd1;
        endcase
    end

    assign w_phase_last = (cnt_q == (w_phase_len - 16'd1));

    // Next-state, phase counter, done pulse and press counter
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        press_cnt_d = press_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PRESS_B;
                end
            end
            S_PRESS_B: begin
                if (w_phase_last) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_phase_last) begin
                    state_d = S_REL_B;
                end
            end
            S_REL_B: begin
                if (w_phase_last) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (w_phase_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Counter restarts at every phase boundary and idles at zero
        if (state_d != state_q) begin
            cnt_d = 16'd0;
        end else if (state_q != S_IDLE) begin
            cnt_d = cnt_q + 16'd1;
        end

        if ((state_q != S_HOLD) && (state_d == S_HOLD)) begin
            press_cnt_d = press_cnt_q + 8'd1;
        end
    end

`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        w_fb;

    assign w_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Advance the bounce source only while a bounce phase is active
    always_comb begin
        lfsr_d = lfsr_q;
        if ((state_q == S_PRESS_B) || (state_q == S_REL_B)) begin
            lfsr_d = {lfsr_q[14:0], w_fb};
        end
    end

    // LFSR register, reseeded only by reset
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lfsr_q <= c_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign w_bounce_press = lfsr_q[0];
    assign w_bounce_rel   = lfsr_q[0];
`else
    logic w_unused_seed;

    // Without bounce the line simply stays at its pre-phase level
    assign w_bounce_press = 1'b1;
    assign w_bounce_rel   = 1'b0;
    assign w_unused_seed  = ^c_SEED;
`endif

    // Key level for the next cycle; last bounce cycle forces the settled level
    always_comb begin
        key_d = 1'b1;
        case (state_q)
            S_PRESS_B: key_d = w_phase_last ? 1'b0 : w_bounce_press;
            S_HOLD:    key_d = 1'b0;
            S_REL_B:   key_d = w_phase_last ? 1'b1 : w_bounce_rel;
            default:   key_d = 1'b1;
        endcase
    end

    // State and output registers; reset releases the key immediately
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            key_q       <= 1'b1;
            done_q      <= 1'b0;
            press_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            done_q      <= done_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign key_out   = key_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign press_cnt = press_cnt_q;

endmodule
`default_nettype wire
